sdio_spi_burst_ctrl: RTL and testbench

- Command sequencer between the SPI slave byte interface and the SDIO capture FIFO.
- Decodes host command bytes and maintains the SDIO control register.
- Serves control/status reads and runs length-prefixed burst reads that drain the FIFO one byte per SPI transfer, paced by tx-complete.
- Replaces ad-hoc command handling in the SDIO-over-SPI top level.

---
 rtl/sdio_spi_burst_ctrl_if.sv | 45 ++++
 rtl/sdio_spi_burst_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sdio_spi_burst_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdio_spi_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdio_spi_burst_ctrl_if
//   Bundles the SPI-slave byte handshake, the SDIO capture-FIFO read port and
//   the control/status outputs of sdio_spi_burst_ctrl.
//
//   slave  modport : seen by the controller (SPI/FIFO inputs, control outputs)
//   master modport : seen by whatever drives the controller (SPI slave + FIFO)
//
//   Signals:
//     rx_valid/rx_data   received SPI byte, one-cycle pulse
//     tx_done            SPI slave finished shifting tx_data
//     tx_data            byte for the next SPI transfer
//     fifo_rd            one-cycle FIFO pop strobe
//     fifo_dat           FIFO read data, valid the cycle after fifo_rd
//     fifo_empty         FIFO empty flag
//     fifo_level         FIFO occupancy (LVL_W bits)
//     ctrl_reg / sd_en   SDIO control register and its enable bit
//     busy / burst_err   sequencer not idle / sticky burst error
// ---------------------------------------------------------------------------
interface sdio_spi_burst_ctrl_if #(
    parameter int LVL_W = 6
);
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             tx_done;
    logic [7:0]       tx_data;
    logic             fifo_rd;
    logic [7:0]       fifo_dat;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       ctrl_reg;
    logic             sd_en;
    logic             busy;
    logic             burst_err;

    modport slave (
        input  rx_valid, rx_data, tx_done, fifo_dat, fifo_empty, fifo_level,
        output tx_data, fifo_rd, ctrl_reg, sd_en, busy, burst_err
    );

    modport master (
        output rx_valid, rx_data, tx_done, fifo_dat, fifo_empty, fifo_level,
        input  tx_data, fifo_rd, ctrl_reg, sd_en, busy, burst_err
    );
endinterface

// File: rtl/sdio_spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// sdio_spi_burst_ctrl
//   Command sequencer between the SPI slave byte interface and the SDIO
//   capture FIFO. Decodes host command bytes:
//     0x02 <b>   write SDIO control register
//     0x03       load control register into tx_data
//     0x05       load status {burst_err, fifo_empty, level} into tx_data,
//                clearing burst_err
//     0xCC <n>   burst read of n FIFO bytes, one per SPI transfer, paced by
//                tx_done; ABORT_BYTE received mid-burst aborts it
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   io_bus  sdio_spi_burst_ctrl_if.slave (see interface file); the interface
//           instance must use the same LVL_W as this module
//
// Parameters:
//   LVL_W       FIFO level width (1..6)
//   ABORT_BYTE  byte that aborts a running burst
//   FILL_BYTE   byte loaded on empty-wait timeout (timeout build only)
//   TIMEOUT     empty-wait cycles before fill (timeout build only)
//
// Build option:
//   SDIO_SPI_BURST_TIMEOUT_EN  when defined, a burst stalled on an empty FIFO
//   for TIMEOUT cycles sends FILL_BYTE instead and flags burst_err. When not
//   defined the burst waits for data indefinitely.
// ---------------------------------------------------------------------------
module sdio_spi_burst_ctrl #(
    parameter int         LVL_W      = 6,
    parameter logic [7:0] ABORT_BYTE = 8'hA5,
    parameter logic [7:0] FILL_BYTE  = 8'hFF,
    parameter int         TIMEOUT    = 1024
) (
    input logic                  clk,
    input logic                  rst,
    sdio_spi_burst_ctrl_if.slave io_bus
);

    localparam logic [7:0] CMD_WR_CTRL = 8'h02;
    localparam logic [7:0] CMD_RD_CTRL = 8'h03;
    localparam logic [7:0] CMD_STATUS  = 8'h05;
    localparam logic [7:0] CMD_BURST   = 8'hCC;

    // FETCH is the cycle fifo_rd is high; the FIFO answers one cycle later,
    // which is the cycle LOAD captures fifo_dat. This gives the two-cycle
    // pop-to-tx_data latency.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CTRL,
        S_GET_LEN,
        S_POP,
        S_FETCH,
        S_LOAD,
        S_WAIT_TX
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [7:0] r_ctrl, w_ctrl_nxt;
    logic       r_fifo_rd, w_fifo_rd_nxt;
    logic       r_burst_err, w_burst_err_nxt;
    logic [7:0] r_remaining, w_remaining_nxt;

    logic       w_abort;
    logic [5:0] w_level6;
    logic [7:0] w_status;

    assign w_abort  = io_bus.rx_valid && (io_bus.rx_data == ABORT_BYTE);
    assign w_level6 = 6'(io_bus.fifo_level);
    assign w_status = {r_burst_err, io_bus.fifo_empty, w_level6};

`ifdef SDIO_SPI_BURST_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic             w_timeout;

    // Fires on the TIMEOUT-th consecutive empty cycle spent in POP.
    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{FILL_BYTE, TIMEOUT[7:0]};
`endif

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tx_data   <= 8'h00;
            r_ctrl      <= 8'h00;
            r_fifo_rd   <= 1'b0;
            r_burst_err <= 1'b0;
            r_remaining <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_fifo_rd   <= w_fifo_rd_nxt;
            r_burst_err <= w_burst_err_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

`ifdef SDIO_SPI_BURST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state and next-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_tx_data_nxt   = r_tx_data;
        w_ctrl_nxt      = r_ctrl;
        w_fifo_rd_nxt   = 1'b0;
        w_burst_err_nxt = r_burst_err;
        w_remaining_nxt = r_remaining;
`ifdef SDIO_SPI_BURST_TIMEOUT_EN
        w_wait_cnt_nxt  = r_wait_cnt;
`endif

        unique case (r_state)
            S_IDLE: begin
                if (io_bus.rx_valid) begin
                    case (io_bus.rx_data)
                        CMD_WR_CTRL: w_state_nxt = S_WR_CTRL;
                        CMD_RD_CTRL: w_tx_data_nxt = r_ctrl;
                        CMD_STATUS: begin
                            // Snapshot holds the pre-clear error bit.
                            w_tx_data_nxt   = w_status;
                            w_burst_err_nxt = 1'b0;
                        end
                        CMD_BURST:   w_state_nxt = S_GET_LEN;
                        default:     ;
                    endcase
                end
            end

            S_WR_CTRL: begin
                if (io_bus.rx_valid) begin
                    w_ctrl_nxt  = io_bus.rx_data;
                    w_state_nxt = S_IDLE;
                end
            end

            S_GET_LEN: begin
                if (io_bus.rx_valid) begin
                    w_remaining_nxt = io_bus.rx_data;
                    w_state_nxt     = (io_bus.rx_data == 8'h00) ? S_IDLE : S_POP;
                end
            end

            S_POP: begin
                if (w_abort) begin
                    w_burst_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (!io_bus.fifo_empty) begin
                    w_fifo_rd_nxt = 1'b1;
                    w_state_nxt   = S_FETCH;
                end
`ifdef SDIO_SPI_BURST_TIMEOUT_EN
                else if (w_timeout) begin
                    // Behaves like LOAD with FILL_BYTE as data; no pop.
                    w_tx_data_nxt   = FILL_BYTE;
                    w_remaining_nxt = r_remaining - 8'd1;
                    w_burst_err_nxt = 1'b1;
                    w_state_nxt     = (r_remaining <= 8'd1) ? S_IDLE : S_WAIT_TX;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
`endif
            end

            S_FETCH: w_state_nxt = S_LOAD;

            S_LOAD: begin
                w_tx_data_nxt = io_bus.fifo_dat;
                // remaining is always >= 1 here; the guard keeps it from
                // ever wrapping.
                if (r_remaining != 8'd0) begin
                    w_remaining_nxt = r_remaining - 8'd1;
                end
                w_state_nxt = (r_remaining <= 8'd1) ? S_IDLE : S_WAIT_TX;
            end

            S_WAIT_TX: begin
                // Abort takes priority over a coincident tx_done.
                if (w_abort) begin
                    w_burst_err_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (io_bus.tx_done) begin
                    w_state_nxt = S_POP;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

`ifdef SDIO_SPI_BURST_TIMEOUT_EN
        if (w_state_nxt != S_POP) begin
            w_wait_cnt_nxt = '0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign io_bus.tx_data   = r_tx_data;
    assign io_bus.fifo_rd   = r_fifo_rd;
    assign io_bus.ctrl_reg  = r_ctrl;
    assign io_bus.sd_en     = r_ctrl[0];
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.burst_err = r_burst_err;

endmodule

// File: tb/tb_sdio_spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdio_spi_burst_ctrl
//   Directed + randomized bench for sdio_spi_burst_ctrl. A queue-based FIFO
//   model feeds the DUT; expected burst bytes come from the order bytes were
//   written to that FIFO, status from the model's own occupancy count.
// ---------------------------------------------------------------------------
module tb_sdio_spi_burst_ctrl;
    localparam int LVL_W = 6;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdio_spi_burst_ctrl_if #(.LVL_W(LVL_W)) bus ();

    sdio_spi_burst_ctrl #(
        .LVL_W(LVL_W), .ABORT_BYTE(8'hA5), .FILL_BYTE(8'hFF), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );

    // ---------------- FIFO model ----------------
    logic [7:0] fq[$];
    logic [7:0] push_buf [0:63];
    int         push_n   = 0;
    logic       push_go  = 1'b0;
    logic       flush_go = 1'b0;
    int         rd_cnt   = 0;

    always @(posedge clk) begin
        if (flush_go) fq.delete();
        if (bus.fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (fq.size() > 0) bus.fifo_dat <= fq.pop_front();
            else               bus.fifo_dat <= 8'hEE;
        end
        if (push_go) for (int i = 0; i < push_n; i++) fq.push_back(push_buf[i]);
        bus.fifo_empty <= (fq.size() == 0);
        bus.fifo_level <= 6'(fq.size());
    end

    // ---------------- reference model state ----------------
    logic [7:0] exp_q[$];     // bytes the FIFO should hand out, in order
    logic [7:0] tx_m   = 8'h00;
    logic       err_m  = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic tx_pulse();
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    // push_buf[0..n-1] must be filled by the caller
    task automatic push(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(push_buf[i]);
        push_n  = n;
        push_go = 1'b1;
        @(negedge clk);
        push_go = 1'b0;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_buf[i] = 8'($urandom);
        push(n);
    endtask

    task automatic flush();
        flush_go = 1'b1;
        @(negedge clk);
        flush_go = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_rd(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.fifo_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Runs the data phase of a burst of len bytes (0xCC, len already sent).
    // abort_after>0 aborts (with a coincident tx_done) after that many bytes.
    task automatic burst(input int len, input int abort_after);
        bit         ok;
        int         base;
        logic [7:0] e;
        base = rd_cnt;
        for (int k = 0; k < len; k++) begin
            wait_rd("burst_pop_seen", ok);
            if (!ok) return;
            tick(1);
            chk("tx_before_latency", 32'(bus.tx_data), 32'(tx_m));
            tick(1);
            e    = exp_q.pop_front();
            tx_m = e;
            chk("burst_tx", 32'(bus.tx_data), 32'(e));
            if (k == len - 1) begin
                chk("busy_after_last", 32'(bus.busy), 32'd0);
                break;
            end
            chk("busy_mid_burst", 32'(bus.busy), 32'd1);
            if (abort_after == k + 1) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = 8'hA5;
                bus.tx_done  = 1'b1;
                @(negedge clk);
                bus.rx_valid = 1'b0;
                bus.tx_done  = 1'b0;
                err_m = 1'b1;
                tick(3);
                chk("abort_idle", 32'(bus.busy), 32'd0);
                chk("abort_err", 32'(bus.burst_err), 32'd1);
                chk("abort_tx_kept", 32'(bus.tx_data), 32'(tx_m));
                chk("abort_pops", rd_cnt, base + k + 1);
                return;
            end
            // Command-looking dummy byte must be ignored while busy.
            send(8'h03);
            tick($urandom_range(0, 4));
            chk("tx_hold_until_done", 32'(bus.tx_data), 32'(tx_m));
            chk("no_pop_before_done", rd_cnt, base + k + 1);
            tx_pulse();
        end
        tick(2);
        chk("burst_pop_count", rd_cnt, base + len);
    endtask

    task automatic status_chk();
        logic [7:0] s;
        s = {err_m, (exp_q.size() == 0), 6'(exp_q.size())};
        send(8'h05);
        tx_m  = s;
        err_m = 1'b0;
        chk("status_tx", 32'(bus.tx_data), 32'(s));
        chk("status_err_clear", 32'(bus.burst_err), 32'd0);
    endtask

    initial begin
        bit         seen;
        bit         ok;
        int         base;
        logic [7:0] v;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_done  = 1'b0;
        rst = 1'b1;
        tick(2);

        // Reset state
        chk("rst_tx", 32'(bus.tx_data), 32'h00);
        chk("rst_ctrl", 32'(bus.ctrl_reg), 32'h00);
        chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_err", 32'(bus.burst_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sd_en", 32'(bus.sd_en), 32'd0);
        rst = 1'b0;
        tick(1);

        // Control write / read
        send(8'h02); send(8'h5A);
        chk("ctrl_wr", 32'(bus.ctrl_reg), 32'h5A);
        chk("sd_en_lo", 32'(bus.sd_en), 32'd0);
        send(8'h03);
        tx_m = 8'h5A;
        chk("ctrl_rd", 32'(bus.tx_data), 32'h5A);
        send(8'h02); send(8'h01);
        chk("sd_en_hi", 32'(bus.sd_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            send(8'h02); send(v);
            send(8'h03);
            tx_m = v;
            chk("ctrl_rand_rd", 32'(bus.tx_data), 32'(v));
            chk("ctrl_rand_sd_en", 32'(bus.sd_en), 32'(v[0]));
        end
        send(8'h77);   // unknown command: ignored
        tick(1);
        chk("unknown_cmd_idle", 32'(bus.busy), 32'd0);
        chk("unknown_cmd_tx", 32'(bus.tx_data), 32'(tx_m));

        // Directed burst of 3
        push_buf[0] = 8'h11; push_buf[1] = 8'h22; push_buf[2] = 8'h33;
        push(3);
        send(8'hCC); send(8'h03);
        burst(3, 0);

        // Random bursts
        for (int i = 0; i < 5; i++) begin
            int n;
            n = $urandom_range(1, 8);
            push_rand(n);
            send(8'hCC); send(8'(n));
            burst(n, 0);
        end

        // Zero length
        base = rd_cnt;
        send(8'hCC); send(8'h00);
        tick(3);
        chk("zero_len_pops", rd_cnt, base);
        chk("zero_len_idle", 32'(bus.busy), 32'd0);

`ifndef SDIO_SPI_BURST_TIMEOUT_EN
        // Empty wait: nothing popped until data lands
        base = rd_cnt;
        send(8'hCC); send(8'h02);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.fifo_rd === 1'b1) seen = 1'b1;
        end
        chk("empty_no_pop", 32'(seen), 32'd0);
        chk("empty_busy", 32'(bus.busy), 32'd1);
        push_rand(2);
        burst(2, 0);
`endif

        // Abort after 2nd byte of 5, then status with level 4
        push_rand(6);
        send(8'hCC); send(8'h05);
        burst(5, 2);
        status_chk();
        chk("status_abort_level4", 32'(tx_m), 32'h84);
        flush();
        tick(1);

`ifdef SDIO_SPI_BURST_TIMEOUT_EN
        // Timeout on empty FIFO
        base = rd_cnt;
        send(8'hCC); send(8'h01);
        tick(TMO - 1);
        chk("tmo_not_yet", 32'(bus.tx_data), 32'(tx_m));
        tick(1);
        tx_m  = 8'hFF;
        err_m = 1'b1;
        chk("tmo_fill", 32'(bus.tx_data), 32'hFF);
        chk("tmo_err", 32'(bus.burst_err), 32'd1);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
        chk("tmo_no_pop", rd_cnt, base);
`endif

        // Async reset while waiting for tx_done
        push_rand(4);
        send(8'hCC); send(8'h04);
        wait_rd("rst_burst_pop_seen", ok);
        tick(3);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", 32'(bus.tx_data), 32'h00);
        chk("arst_ctrl", 32'(bus.ctrl_reg), 32'h00);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("arst_err", 32'(bus.burst_err), 32'd0);
        chk("arst_sd_en", 32'(bus.sd_en), 32'd0);
        base = rd_cnt;
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("arst_no_pop", rd_cnt, base);
        chk("arst_idle_after", 32'(bus.busy), 32'd0);
        flush();
        tx_m  = 8'h00;
        err_m = 1'b0;
        tick(1);
        status_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
